jt_ps2_keydec: RTL and testbench



---
 rtl/jt_ps2_keydec.sv | 215 +++++++++++++++++++++
 tb/tb_jt_ps2_keydec.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt_ps2_keydec.sv
// jt_ps2_keydec: host-side PS/2 keyboard receiver (scan code set 2).
// Conditions the raw PS/2 pins, deframes 11-bit frames and turns the byte
// stream into {toggle, pressed, extended, code} key events on clk_sys.
module jt_ps2_keydec #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 12000
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err,
   output logic        busy
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   // Keyboard replies and fillers that carry no key information on their own.
   function automatic logic is_filler(input logic [7:0] b);
      logic hit;
      case (b)
         8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: hit = 1'b1;
         default:                                         hit = 1'b0;
      endcase
      return hit;
   endfunction

   logic           clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
   logic           filt_clk_r, filt_clk_d_r;
   logic [FCW-1:0] filt_cnt_r;
   logic           strobe_s;
   state_t         state_r, state_s;
   logic [2:0]     bit_cnt_r, bit_cnt_s;
   logic [7:0]     shift_r, shift_s;
   logic           par_err_r, par_err_s;
   logic           byte_ok_s, err_s, timeout_s;
   logic [TCW-1:0] to_cnt_r;
   logic [7:0]     byte_r;
   logic           byte_vld_r, tmo_r, frame_err_r, busy_r;
   logic           ext_r, brk_r;
   logic [2:0]     skip_cnt_r;
   logic [10:0]    key_r;

   // Two-flop synchronisers for the asynchronous pins; idle bus level is high.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
      end else begin
         clk_meta_r  <= ps2_clk;
         clk_sync_r  <= clk_meta_r;
         data_meta_r <= ps2_data;
         data_sync_r <= data_meta_r;
      end
   end

   // Clock deglitcher: adopt a new level only after FILTER_LEN equal samples.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         filt_clk_r   <= 1'b1;
         filt_clk_d_r <= 1'b1;
         filt_cnt_r   <= '0;
      end else begin
         filt_clk_d_r <= filt_clk_r;
         if (clk_sync_r == filt_clk_r) begin
            filt_cnt_r <= '0;
         end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
            filt_clk_r <= clk_sync_r;
            filt_cnt_r <= '0;
         end else begin
            filt_cnt_r <= filt_cnt_r + FCW'(1);
         end
      end
   end

   assign strobe_s = filt_clk_d_r & ~filt_clk_r;

   // Inactivity counter: restarts on every strobe, runs only mid-frame.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         to_cnt_r <= '0;
      end else if (strobe_s || (state_r == ST_IDLE)) begin
         to_cnt_r <= '0;
      end else if (to_cnt_r != TCW'(TIMEOUT - 1)) begin
         to_cnt_r <= to_cnt_r + TCW'(1);
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end

   // Frame FSM next state: start, 8 data bits LSB first, parity, stop.
   always_comb begin
      state_s   = state_r;
      bit_cnt_s = bit_cnt_r;
      shift_s   = shift_r;
      par_err_s = par_err_r;
      byte_ok_s = 1'b0;
      err_s     = 1'b0;
      timeout_s = 1'b0;
      if ((state_r != ST_IDLE) && !strobe_s && (to_cnt_r == TCW'(TIMEOUT - 1))) begin
         state_s   = ST_IDLE;
         err_s     = 1'b1;
         timeout_s = 1'b1;
      end else if (strobe_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!data_sync_r) begin
                  state_s   = ST_DATA;
                  bit_cnt_s = 3'd0;
               end else begin
                  err_s = 1'b1;
               end
            end
            ST_DATA: begin
               shift_s = {data_sync_r, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_s = ST_PARITY;
               end else begin
                  bit_cnt_s = bit_cnt_r + 3'd1;
               end
            end
            ST_PARITY: begin
               par_err_s = ~odd_parity_ok(shift_r, data_sync_r);
               state_s   = ST_STOP;
            end
            ST_STOP: begin
               if (data_sync_r && !par_err_r) begin
                  byte_ok_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
               state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Frame FSM registers plus the registered frame-level outputs.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         par_err_r   <= 1'b0;
         byte_r      <= 8'h00;
         byte_vld_r  <= 1'b0;
         tmo_r       <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         bit_cnt_r   <= bit_cnt_s;
         shift_r     <= shift_s;
         par_err_r   <= par_err_s;
         byte_r      <= shift_r;
         byte_vld_r  <= byte_ok_s;
         tmo_r       <= timeout_s;
         frame_err_r <= err_s;
         busy_r      <= (state_s != ST_IDLE);
      end
   end

   // Byte decoder: prefixes, Pause-sequence skipping, filler drop, events.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         ext_r      <= 1'b0;
         brk_r      <= 1'b0;
         skip_cnt_r <= 3'd0;
         key_r      <= 11'h000;
      end else if (tmo_r) begin
         ext_r <= 1'b0;
         brk_r <= 1'b0;
      end else if (byte_vld_r) begin
         if (skip_cnt_r != 3'd0) begin
            skip_cnt_r <= skip_cnt_r - 3'd1;
         end else begin
            case (byte_r)
               8'hE0:   ext_r      <= 1'b1;
               8'hF0:   brk_r      <= 1'b1;
               8'hE1:   skip_cnt_r <= 3'd7;
               default: begin
                  if (is_filler(byte_r) && !ext_r && !brk_r) begin
                     key_r <= key_r;
                  end else begin
                     key_r <= {~key_r[10], ~brk_r, ext_r, byte_r};
                     ext_r <= 1'b0;
                     brk_r <= 1'b0;
                  end
               end
            endcase
         end
      end else begin
         key_r <= key_r;
      end
   end

   assign ps2_key   = key_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_jt_ps2_keydec.sv
// Bench for jt_ps2_keydec: directed test-plan cases plus randomized frames,
// all checked against a byte-level keyboard model kept in the bench.
module tb_jt_ps2_keydec;

   localparam int HALF    = 20;     // PS/2 half period in clk_sys cycles
   localparam int TIMEOUT = 12000;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;
   logic        busy;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [10:0] exp_key = 11'h000;
   int          exp_err = 0;
   int          err_seen = 0;
   int          err_cyc = 0;
   bit          in_rst = 1'b1;
   bit          prev_err = 1'b0;
   bit          m_ext = 1'b0;
   bit          m_brk = 1'b0;
   int          m_skip = 0;
   logic [7:0]  fillers [7] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
   logic [7:0]  specials [10] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

   jt_ps2_keydec #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   function automatic bit filler(input logic [7:0] b);
      bit hit = 1'b0;
      foreach (fillers[i]) if (fillers[i] == b) hit = 1'b1;
      return hit;
   endfunction

   // Keyboard-handler model: what one valid byte does to the expected event word.
   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0)                              m_skip--;
      else if (b == 8'hE0)                         m_ext = 1'b1;
      else if (b == 8'hF0)                         m_brk = 1'b1;
      else if (b == 8'hE1)                         m_skip = 7;
      else if (filler(b) && !m_ext && !m_brk)      m_skip = 0;
      else begin
         exp_key = {~exp_key[10], ~m_brk, m_ext, b};
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   // Per-cycle compare of the event word, plus frame_err pulse bookkeeping.
   always @(negedge clk_sys) begin
      if (!in_rst) begin
         check("ps2_key", 32'(ps2_key), 32'(exp_key));
         check("err_pulse_width", 32'(frame_err & prev_err), 32'd0);
         if (frame_err === 1'b1) begin
            err_seen++;
            err_cyc = cyc;
         end
         prev_err = frame_err;
      end else begin
         prev_err = 1'b0;
      end
   end

   // One full 11-bit frame; the model updates exactly 2 cycles after the stop strobe
   // (stop strobe lands 10 clk_sys edges after the pin falls).
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] fr;
      fr[0]   = 1'b0;
      fr[8:1] = b;
      fr[9]   = ~(^b) ^ bad_par;
      fr[10]  = ~bad_stop;
      for (int i = 0; i < 11; i++) begin
         ps2_data = fr[i];
         tick(HALF);
         ps2_clk = 1'b0;
         if (i == 10) begin
            tick(12);
            if (bad_par || bad_stop) exp_err++;
            else                     model_byte(b);
            tick(HALF - 12);
         end else begin
            tick(HALF);
            if (i == 1) check("busy_mid_frame", 32'(busy), 32'd1);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(HALF);
      check("busy_after_frame", 32'(busy), 32'd0);
      check("err_count", 32'(err_seen), 32'(exp_err));
   endtask

   // Lone clock pulse with data high: a bad start bit.
   task automatic send_stray();
      ps2_data = 1'b1;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
      tick(HALF);
      exp_err++;
      check("stray_err_count", 32'(err_seen), 32'(exp_err));
      check("stray_busy", 32'(busy), 32'd0);
   endtask

   // Start bit plus n data bits, then stop clocking; returns the cycle of the last fall.
   task automatic send_partial(input int n, output int last_fall);
      last_fall = 0;
      for (int i = 0; i <= n; i++) begin
         ps2_data = (i == 0) ? 1'b0 : 1'(i & 1);
         tick(HALF);
         ps2_clk = 1'b0;
         last_fall = cyc;
         tick(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(HALF);
   endtask

   initial begin
      int lf;
      int w;
      logic [7:0] b;
      bit bp, bs;

      // Reset state
      tick(4);
      check("rst_key", 32'(ps2_key), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      tick(2);
      in_rst = 1'b0;

      // Make key A
      send_frame(8'h1C, 1'b0, 1'b0);
      check("make_A", 32'(ps2_key), 32'h61C);

      // Extended break: E0 F0 75
      send_frame(8'hE0, 1'b0, 1'b0);
      check("no_evt_E0", 32'(ps2_key), 32'h61C);
      send_frame(8'hF0, 1'b0, 1'b0);
      check("no_evt_F0", 32'(ps2_key), 32'h61C);
      send_frame(8'h75, 1'b0, 1'b0);
      check("break_ext", 32'(ps2_key), 32'h175);

      // Bad parity, then a clean frame
      send_frame(8'h1C, 1'b1, 1'b0);
      check("bad_par_key", 32'(ps2_key), 32'h175);
      check("bad_par_err", 32'(err_seen), 32'd1);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("after_bad_par", 32'(ps2_key), 32'h61C);

      // Timeout after a pending E0; timeout must also drop the prefix
      send_frame(8'hE0, 1'b0, 1'b0);
      send_partial(3, lf);
      check("busy_partial", 32'(busy), 32'd1);
      w = 0;
      while (err_seen == exp_err && w < TIMEOUT + 500) begin
         tick(1);
         w++;
      end
      check("timeout_fired", 32'(err_seen), 32'(exp_err + 1));
      check("timeout_latency_ok",
            32'((err_cyc - lf) >= TIMEOUT && (err_cyc - lf) <= TIMEOUT + 30), 32'd1);
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      tick(2);
      check("timeout_busy", 32'(busy), 32'd0);
      send_frame(8'h29, 1'b0, 1'b0);
      check("after_timeout", 32'(ps2_key), 32'h229);

      // Pause sequence and filler
      foreach (specials[i]) if (i < 0) b = specials[i];
      begin
         logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA};
         foreach (seq[i]) send_frame(seq[i], 1'b0, 1'b0);
      end
      check("pause_no_evt", 32'(ps2_key), 32'h229);
      send_frame(8'h05, 1'b0, 1'b0);
      check("after_pause", 32'(ps2_key), 32'h605);

      // Glitches from 1 to FILTER_LEN-1 cycles: no strobe at all
      for (int g = 1; g < 8; g++) begin
         ps2_clk = 1'b0;
         tick(g);
         ps2_clk = 1'b1;
         tick(15);
         check("glitch_busy", 32'(busy), 32'd0);
      end
      check("glitch_err", 32'(err_seen), 32'(exp_err));

      // Reset mid-frame
      send_partial(4, lf);
      check("busy_before_rst", 32'(busy), 32'd1);
      in_rst = 1'b1;
      rst = 1'b1;
      tick(3);
      check("midrst_key", 32'(ps2_key), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      exp_key = 11'h000;
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_skip = 0;
      tick(2);
      in_rst = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b0);
      check("after_rst", 32'(ps2_key), 32'h61C);

      // Filler byte with a break prefix pending still produces an event
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'hAA, 1'b0, 1'b0);
      check("filler_with_prefix", 32'(ps2_key), 32'h0AA);

      // Randomized traffic
      for (int k = 0; k < 50; k++) begin
         if ($urandom_range(0, 99) < 5) begin
            send_stray();
         end else begin
            if ($urandom_range(0, 2) == 0) b = specials[$urandom_range(0, 9)];
            else                           b = 8'($urandom);
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 19) == 0);
            send_frame(b, bp, bs);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1);
   end

endmodule
